// File: rtl/matmul_sched.sv
// matmul_sched: round-robin scheduler sharing one matmul engine among NREQ requesters.
// Ports: clk/rstn, per-requester req/dims/operands, grant/done/err, load/result streams, engine side.

package matmul_pkg;
  typedef struct packed {
    int rows;
    int cols;
  } matmul_dims_t;

  typedef enum logic [2:0] {
    MM_IDLE,
    MM_READ,
    MM_CALCULATE,
    MM_WRITE,
    MM_ERROR
  } matmul_state_t;
endpackage

module matmul_sched
  import matmul_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int BUF_SIZE = 1024,
  parameter int TIMEOUT  = 65536
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [NREQ-1:0] req,
  input  matmul_dims_t  req_dims_a [NREQ],
  input  matmul_dims_t  req_dims_b [NREQ],
  input  int            req_in_a [NREQ],
  input  int            req_in_b [NREQ],
  output logic [NREQ-1:0] grant,
  output logic          ld_active,
  output int            ld_idx,
  output logic          out_valid,
  output int            out_data,
  output int            out_idx,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] err,
  output logic          busy,
  output logic          eng_start,
  output matmul_dims_t  eng_dims_a,
  output matmul_dims_t  eng_dims_b,
  output int            eng_in_a,
  output int            eng_in_b,
  input  matmul_state_t eng_state,
  input  int            eng_out_c
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_START,
    S_LOAD,
    S_CALC,
    S_DRAIN,
    S_DONE
  } st_t;

  st_t            st;
  logic           fl_first;
  logic           dr_first;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  owner;
  int             n_ld;
  int             out_cnt;
  int             wd_cnt;

  logic           found;
  logic [IW-1:0]  win;
  logic [IW-1:0]  jj;
  int             j;
  matmul_dims_t   wa;
  matmul_dims_t   wb;
  longint         pa;
  longint         pb;
  logic           win_ok;
  logic           wd_hit;
  logic           abort;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return (int'(x) >= NREQ - 1) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
  end

  assign wa = req_dims_a[win];
  assign wb = req_dims_b[win];
  assign pa = longint'(wa.rows) * longint'(wa.cols);
  assign pb = longint'(wb.rows) * longint'(wb.cols);

  // Engine READ needs equal element counts for both operands.
  assign win_ok = (wa.cols == wb.rows) &&
                  (wa.rows > 0) && (wa.cols > 0) &&
                  (wb.rows > 0) && (wb.cols > 0) &&
                  (pa == pb) &&
                  (pa < longint'(BUF_SIZE)) &&
                  (pb < longint'(BUF_SIZE));

  // START is uncounted and err is registered, so firing two
  // counts early lands err exactly TIMEOUT cycles after START.
  assign wd_hit = (wd_cnt + 2 == TIMEOUT);

  assign abort = (st inside {S_START, S_LOAD, S_CALC, S_DRAIN}) &&
                 (wd_hit || eng_state == MM_ERROR);

  assign busy      = (st != S_IDLE);
  assign out_valid = (st == S_DRAIN) && !dr_first &&
                     (eng_state == MM_WRITE);
  assign out_data  = out_valid ? eng_out_c : 0;
  assign out_idx   = out_valid ? out_cnt : 0;
  assign eng_in_a  = ld_active ? req_in_a[owner] : 0;
  assign eng_in_b  = ld_active ? req_in_b[owner] : 0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= S_FLUSH;
      fl_first   <= 1'b1;
      dr_first   <= 1'b0;
      grant      <= '0;
      done       <= '0;
      err        <= '0;
      ld_active  <= 1'b0;
      ld_idx     <= 0;
      eng_start  <= 1'b0;
      eng_dims_a <= '0;
      eng_dims_b <= '0;
      ptr        <= '0;
      owner      <= '0;
      n_ld       <= 0;
      out_cnt    <= 0;
      wd_cnt     <= 0;
    end else begin
      done <= '0;
      err  <= '0;
      if (st inside {S_LOAD, S_CALC, S_DRAIN})
        wd_cnt <= wd_cnt + 1;
      if (abort) begin
        err[owner] <= 1'b1;
        grant      <= '0;
        ptr        <= nxt(owner);
        st         <= S_FLUSH;
        fl_first   <= 1'b1;
        eng_start  <= 1'b0;
        eng_dims_a <= '0;
        eng_dims_b <= '0;
        ld_active  <= 1'b0;
        ld_idx     <= 0;
        out_cnt    <= 0;
      end else begin
        unique case (st)
          S_FLUSH: begin
            if (fl_first) begin
              eng_start <= 1'b1;
              fl_first  <= 1'b0;
            end else begin
              eng_start <= 1'b0;
              if (!eng_start && eng_state == MM_IDLE)
                st <= S_IDLE;
            end
          end
          S_IDLE: begin
            if (found) begin
              if (win_ok) begin
                owner      <= win;
                grant      <= NREQ'(1) << win;
                eng_dims_a <= wa;
                eng_dims_b <= wb;
                n_ld       <= int'(pa);
                eng_start  <= 1'b1;
                wd_cnt     <= 0;
                st         <= S_START;
              end else begin
                err[win] <= 1'b1;
                ptr      <= nxt(win);
              end
            end
          end
          S_START: begin
            eng_start <= 1'b0;
            ld_active <= 1'b1;
            ld_idx    <= 0;
            st        <= S_LOAD;
          end
          S_LOAD: begin
            if (ld_idx == n_ld - 1) begin
              ld_active <= 1'b0;
              ld_idx    <= 0;
              st        <= S_CALC;
            end else begin
              ld_idx <= ld_idx + 1;
            end
          end
          S_CALC: begin
            if (eng_state == MM_WRITE) begin
              dr_first <= 1'b1;
              out_cnt  <= 0;
              st       <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            dr_first <= 1'b0;
            if (out_valid)
              out_cnt <= out_cnt + 1;
            if (eng_state == MM_IDLE) begin
              done[owner] <= 1'b1;
              out_cnt     <= 0;
              st          <= S_DONE;
            end
          end
          S_DONE: begin
            grant <= '0;
            ptr   <= nxt(owner);
            st    <= S_IDLE;
          end
          default: st <= S_FLUSH;
        endcase
      end
    end
  end

endmodule
